// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types for the register-file write side.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Register-file write-port bundle at the default data width.
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
    } wb_port_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding multi-cycle results until the write port is free.
// Push is ignored when full and pop is ignored when empty, so a push and a pop
// may both happen in one cycle only when the FIFO is neither full nor empty.
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Flags come straight from the registered count.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // Storage: data needs no reset, the count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gpr_writeback.sv
// Register-file write-side controller: arbitrates the single write port between
// pipeline results (A, highest priority) and queued multi-cycle results (B),
// and keeps a busy scoreboard so decode can stall on pending B destinations.
// Optional feature macro: GPR_WB_BYPASS_EN forwards the registered write into
// the operand read path.
module gpr_writeback #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DATA_W     = cpu_pkg::DATA_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           a_valid,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0]              a_data,
    input  logic                           b_valid,
    output logic                           b_ready,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0]              b_data,
    input  logic                           mark_valid,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] mark_addr,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] rs_addr,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] rt_addr,
    output logic                           stall,
    output logic                           we,
    output logic [cpu_pkg::REG_ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0]              wdata,
    input  logic [DATA_W-1:0]              rd1_in,
    input  logic [DATA_W-1:0]              rd2_in,
    output logic [DATA_W-1:0]              rs_data,
    output logic [DATA_W-1:0]              rt_data
);

    import cpu_pkg::*;

    localparam int unsigned ENTRY_W = REG_ADDR_W + DATA_W;

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic                  we_q;
    logic                  we_d;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic [REG_ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     wdata_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0]     head_data;
    logic                  a_write;

    assign {head_addr, head_data} = fifo_head;

    // No push-on-pop when full: ready depends only on the registered count.
    assign b_ready   = ~fifo_full;
    assign fifo_push = b_valid & ~fifo_full;

    // An A result to r0 is not a write, so it leaves the slot to the FIFO.
    assign a_write  = a_valid & (a_addr != REG_ZERO);
    assign fifo_pop = ~a_write & ~fifo_empty;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({b_addr, b_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Write-port arbitration: A first, then the FIFO head, otherwise idle.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = REG_ZERO;
        wdata_d = '0;
        if (a_write) begin
            we_d    = 1'b1;
            waddr_d = a_addr;
            wdata_d = a_data;
        end else if (fifo_pop && (head_addr != REG_ZERO)) begin
            // A queued r0 result is still popped but never written.
            we_d    = 1'b1;
            waddr_d = head_addr;
            wdata_d = head_data;
        end
    end

    // Scoreboard next state: clear on pop, then set on mark so a same-cycle mark wins.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop && (head_addr != REG_ZERO)) begin
            busy_d[head_addr] = 1'b0;
        end
        if (mark_valid && (mark_addr != REG_ZERO)) begin
            busy_d[mark_addr] = 1'b1;
        end
    end

    // Registered write port and scoreboard; reset drops queued work and busy bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            waddr_q <= REG_ZERO;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

    assign stall = ((rs_addr != REG_ZERO) & busy_q[rs_addr]) |
                   ((rt_addr != REG_ZERO) & busy_q[rt_addr]);

`ifdef GPR_WB_BYPASS_EN
    logic rs_hit;
    logic rt_hit;

    // Forward the write being committed this cycle so decode sees the new value.
    assign rs_hit  = we_q & (waddr_q != REG_ZERO) & (waddr_q == rs_addr);
    assign rt_hit  = we_q & (waddr_q != REG_ZERO) & (waddr_q == rt_addr);
    assign rs_data = rs_hit ? wdata_q : rd1_in;
    assign rt_data = rt_hit ? wdata_q : rd2_in;
`else
    assign rs_data = rd1_in;
    assign rt_data = rd2_in;
`endif

endmodule

// File: tb/tb_gpr_writeback.sv
// Bench for gpr_writeback: a cycle-level model predicts each write-port value,
// queues it when the stimulus is driven and compares it after the clock edge.
module tb_gpr_writeback;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic        mark_valid = 1'b0;
    logic [4:0]  mark_addr = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic        stall;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rd1_in = '0;
    logic [31:0] rd2_in = '0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    always #5 clk = ~clk;

    gpr_writeback #(
        .FIFO_DEPTH (DEPTH),
        .DATA_W     (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .mark_valid (mark_valid),
        .mark_addr  (mark_addr),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .stall      (stall),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .rd1_in     (rd1_in),
        .rd2_in     (rd2_in),
        .rs_data    (rs_data),
        .rt_data    (rt_data)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    wr_t         exp_q[$];
    ent_t        mfifo[$];
    logic [31:0] mbusy = '0;
    wr_t         cur = '0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic idle_inputs();
        a_valid    = 1'b0;
        b_valid    = 1'b0;
        mark_valid = 1'b0;
    endtask

    // One clock: check combinational outputs, advance the model, check the write port.
    task automatic cycle();
        wr_t         e;
        ent_t        h;
        logic        aw;
        logic        mready;
        logic        mstall;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        #1;
        mready = (mfifo.size() < DEPTH);
        mstall = (rs_addr != 0 && mbusy[rs_addr]) || (rt_addr != 0 && mbusy[rt_addr]);
        exp_rs = rd1_in;
        exp_rt = rd2_in;
`ifdef GPR_WB_BYPASS_EN
        if (cur.we && cur.addr != 0 && cur.addr == rs_addr) exp_rs = cur.data;
        if (cur.we && cur.addr != 0 && cur.addr == rt_addr) exp_rt = cur.data;
`endif
        check("b_ready", b_ready, mready);
        check("stall", stall, mstall);
        check("rs_data", rs_data, exp_rs);
        check("rt_data", rt_data, exp_rt);

        e = '0;
        if (reset) begin
            mfifo.delete();
            mbusy = '0;
        end else begin
            aw = a_valid && (a_addr != 0);
            if (aw) begin
                e = '{we: 1'b1, addr: a_addr, data: a_data};
            end else if (mfifo.size() != 0) begin
                h = mfifo.pop_front();
                if (h.addr != 0) begin
                    e = '{we: 1'b1, addr: h.addr, data: h.data};
                    mbusy[h.addr] = 1'b0;
                end
            end
            if (mark_valid && mark_addr != 0) mbusy[mark_addr] = 1'b1;
            if (b_valid && mready) mfifo.push_back('{addr: b_addr, data: b_data});
        end
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("we", we, e.we);
        if (e.we) begin
            check("waddr", waddr, e.addr);
            check("wdata", wdata, e.data);
        end
        cur = e;
    endtask

    initial begin
        logic [4:0] ra;

        // Reset state.
        @(posedge clk);
        #1;
        cycle();
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_ready", b_ready, 1);
        check("rst_stall", stall, 0);
        reset = 1'b0;

        // Pipeline write, then a write to r0.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
        cycle();
        check("a_we", we, 1);
        check("a_waddr", waddr, 5);
        check("a_wdata", wdata, 32'h1234);
        a_addr = 5'd0; a_data = 32'h5555;
        cycle();
        check("a0_we", we, 0);

        // Mark r9, stall on it, then retire it through B.
        idle_inputs();
        mark_valid = 1'b1; mark_addr = 5'd9;
        cycle();
        mark_valid = 1'b0;
        rs_addr = 5'd9;
        #1;
        check("mark_stall", stall, 1);
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hCAFE;
        cycle();
        b_valid = 1'b0;
        cycle();
        check("b_we", we, 1);
        check("b_waddr", waddr, 9);
        check("b_stall_drop", stall, 0);
        rs_addr = 5'd0;

        // A on four cycles while B fills the FIFO; third B push must be refused.
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_addr = 5'(i + 1); a_data = 32'hA0 + i;
            b_valid = (i < 3); b_addr = 5'(10 + i); b_data = 32'hB0 + i;
            if (i == 2) begin
                #1;
                check("full_ready", b_ready, 0);
            end
            cycle();
        end
        idle_inputs();
        cycle();
        check("b1_waddr", waddr, 10);
        check("b1_wdata", wdata, 32'hB0);
        cycle();
        check("b2_waddr", waddr, 11);
        check("b2_wdata", wdata, 32'hB1);
        cycle();
        check("b3_dropped", we, 0);

        // Mark r3 in the same cycle its queued result pops: busy must survive.
        mark_valid = 1'b1; mark_addr = 5'd3; b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h33;
        cycle();
        idle_inputs();
        mark_valid = 1'b1; mark_addr = 5'd3;
        cycle();
        idle_inputs();
        rt_addr = 5'd3;
        #1;
        check("markpop_stall", stall, 1);
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h34;
        cycle();
        idle_inputs();
        cycle();
        rt_addr = 5'd0;

        // Operand forwarding of the registered write.
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hBEEF;
        cycle();
        idle_inputs();
        rt_addr = 5'd7; rd2_in = 32'h0; rd1_in = 32'h1111;
        #1;
`ifdef GPR_WB_BYPASS_EN
        check("byp_rt", rt_data, 32'hBEEF);
`else
        check("byp_rt", rt_data, 32'h0);
`endif
        check("byp_rs", rs_data, 32'h1111);
        rd2_in = 32'h2222;
        cycle();
        check("byp_off", rt_data, 32'h2222);
        rt_addr = 5'd0;

        // Reset with two queued entries and r4 busy: nothing stale may come out.
        mark_valid = 1'b1; mark_addr = 5'd4;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
        cycle();
        mark_valid = 1'b0; a_addr = 5'd2; b_addr = 5'd6; b_data = 32'h66;
        cycle();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        rs_addr = 5'd4;
        #1;
        check("mid_rst_we", we, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_ready", b_ready, 1);
        repeat (4) cycle();
        rs_addr = 5'd0;

        // Random traffic; A never targets a register the model has busy.
        for (int n = 0; n < 400; n++) begin
            ra         = 5'($urandom_range(0, 31));
            a_valid    = ($urandom_range(0, 2) == 0) && !mbusy[ra];
            a_addr     = ra;
            a_data     = $urandom;
            b_valid    = $urandom_range(0, 1) == 1;
            b_addr     = 5'($urandom_range(0, 31));
            b_data     = $urandom;
            mark_valid = $urandom_range(0, 3) == 0;
            mark_addr  = 5'($urandom_range(0, 31));
            rs_addr    = 5'($urandom_range(0, 31));
            rt_addr    = 5'($urandom_range(0, 31));
            rd1_in     = $urandom;
            rd2_in     = $urandom;
            reset      = $urandom_range(0, 63) == 0;
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_writeback.md
# gpr_writeback

Write-side controller for the general-purpose register file in the MIPS core. Merges results from the single-cycle pipeline and the multi-cycle unit (mult/div, long loads) into the register file's single write port. Keeps a 32-entry busy scoreboard so issue can stall on pending multi-cycle destinations. Optionally forwards the in-flight write into the operand read path.

## Interface
Parameters:
- FIFO_DEPTH, 2, multi-cycle result queue entries; power of two, ≥2
- DATA_W, 32, register width

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- a_valid  in  1  pipeline result valid this cycle; no backpressure
- a_addr  in  5  pipeline destination register
- a_data  in  DATA_W  pipeline result
- b_valid  in  1  multi-cycle result valid
- b_ready  out  1  multi-cycle result accepted when b_valid & b_ready
- b_addr  in  5  multi-cycle destination register
- b_data  in  DATA_W  multi-cycle result
- mark_valid  in  1  issue stage dispatched a multi-cycle op
- mark_addr  in  5  its destination register
- rs_addr, rt_addr  in  5 each  operands of the instruction in decode
- stall  out  1  decode operand is busy
- we  out  1  register file write enable
- waddr  out  5  register file write address
- wdata  out  DATA_W  register file write data
- rd1_in, rd2_in  in  DATA_W each  register file read data for rs/rt
- rs_data, rt_data  out  DATA_W each  operand data to decode

## Operation
- Write port arbitration each cycle, priority order: (1) a_valid with a_addr≠0 → we/waddr/wdata from A; (2) FIFO non-empty → pop head, write it; (3) we=0.
- a_valid with a_addr=0: no write; the slot is treated as free, so the FIFO may drain.
- FIFO: push on b_valid & b_ready. b_ready = !full, computed from registered count. b_addr=0 is accepted and popped but produces we=0.
- Scoreboard busy[31:0]: set busy[mark_addr] on mark_valid (mark_addr=0 ignored). Clear busy[addr] on the cycle a FIFO entry pops. Mark and clear of the same register in the same cycle: set wins.
- stall = (rs_addr≠0 & busy[rs_addr]) | (rt_addr≠0 & busy[rt_addr]); combinational from registered busy.
- Pipeline A writes do not touch the scoreboard. Issue guarantees no A write to a busy register.
- rs_data/rt_data: see Configuration.

## Timing
- Reset values: we=0, waddr=0, wdata=0, b_ready=1 (on the cycle after reset), busy=0, FIFO empty, stall=0.
- we/waddr/wdata are registered. An A result appears on the write port exactly 1 cycle after a_valid.
- B latency: accepted at edge N; earliest write at N+1 outputs. Delayed by one cycle for every cycle A occupies the port.
- The busy bit drops at the same edge the write appears on we.
- Full FIFO: b_ready=0 for that cycle even if a pop occurs; no same-cycle push-on-pop.
- Reset mid-operation: FIFO contents and busy bits are discarded, and no pending write is issued.

## Configuration
- GPR_WB_BYPASS_EN defined: if we & waddr≠0 & waddr==rs_addr, then rs_data=wdata, else rd1_in. rt_data is formed the same way from rd2_in. The path is combinational.
- Not defined: rs_data=rd1_in and rt_data=rd2_in unconditionally. There is no comparator logic.

## Structure
- Shared package cpu_pkg holds: REG_ADDR_W=5, NUM_REGS=32, DATA_W default, REG_ZERO=5'd0, and the write-port bundle typedef (we, waddr, wdata).
- Sub-module wb_fifo: a parameterised synchronous FIFO with push/pop/full/empty/head. The rest (arbiter, scoreboard, bypass) lives in gpr_writeback.

## Test plan
- Reset, then a_valid with addr=5, data=0x1234 → next cycle we=1, waddr=5, wdata=0x1234. Issue a_valid with addr=0 → we=0.
- mark addr=9, then rs_addr=9 → stall=1. Push b addr=9, data=0xCAFE with A idle → next cycle we=1, waddr=9, and stall drops at that same edge.
- A valid on 4 consecutive cycles while 2 B results are pushed → b_ready=0 after the 2nd push. The B writes appear in order on cycles 5 and 6, after the A writes.
- mark_valid addr=3 on the same cycle the FIFO pops addr=3 → busy[3] stays 1.
- With GPR_WB_BYPASS_EN: we=1, waddr=7, wdata=0xBEEF, rt_addr=7, rd2_in=0 → rt_data=0xBEEF. With waddr=0 or the macro undefined → rt_data=rd2_in.
- Reset asserted with FIFO holding 2 entries and busy[4]=1 → after reset: we=0, stall=0, b_ready=1, and no stale write ever appears.
